// File: rtl/store_multiple_seq.sv
// Store-multiple sequencer: snapshots a register mask and values, then streams
// the selected registers in ascending index order to consecutive addresses.
module store_multiple_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  mask,
  input  logic [15:0] base_addr,
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [15:0] in3,
  input  logic [15:0] in4,
  input  logic [15:0] in5,
  input  logic [15:0] in6,
  input  logic [15:0] in7,
  output logic [15:0] out_data,
  output logic [15:0] out_addr,
  output logic [2:0]  out_sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FIN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_mask;
  logic [7:0]  w_mask_nxt;
  logic [15:0] r_addr;
  logic [15:0] w_addr_nxt;
  logic [15:0] r_snap [8];
  logic [15:0] w_in [8];
  logic        w_cap;
  logic        w_valid;
  logic [2:0]  w_sel;
  logic [7:0]  w_onehot;

  assign w_in[0] = in0;
  assign w_in[1] = in1;
  assign w_in[2] = in2;
  assign w_in[3] = in3;
  assign w_in[4] = in4;
  assign w_in[5] = in5;
  assign w_in[6] = in6;
  assign w_in[7] = in7;

  // Descending scan so the lowest set bit wins.
  always_comb begin
    w_sel = '0;
    for (int i = 7; i >= 0; i--) begin
      if (r_mask[i]) w_sel = 3'(i);
    end
  end

  assign w_onehot  = 8'b1 << w_sel;
  assign w_valid   = (r_state == SEND);
  assign out_valid = w_valid;
  assign out_sel   = w_valid ? w_sel : '0;
  assign out_data  = w_valid ? r_snap[w_sel] : '0;
  assign out_addr  = w_valid ? r_addr : '0;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FIN);

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_addr_nxt  = r_addr;
    w_cap       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_cap       = 1'b1;
          w_mask_nxt  = mask;
          w_addr_nxt  = base_addr;
          w_state_nxt = (mask != 8'h00) ? SEND : FIN;
        end
      end
      SEND: begin
        if (out_ready) begin
          w_mask_nxt = r_mask & ~w_onehot;
          w_addr_nxt = r_addr + 16'd1;
          if ((r_mask & ~w_onehot) == 8'h00) w_state_nxt = FIN;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_snap[i] <= '0;
    end else if (w_cap) begin
      for (int i = 0; i < 8; i++) r_snap[i] <= w_in[i];
    end
  end

endmodule

// File: tb/tb_store_multiple_seq.sv
// Randomized + directed bench for store_multiple_seq against a queue-based
// model of the expected (sel, data, addr) transfer list.
module tb_store_multiple_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  mask;
  logic [15:0] base_addr;
  logic [15:0] vin [8];
  logic [15:0] out_data;
  logic [15:0] out_addr;
  logic [2:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  store_multiple_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mask      (mask),
    .base_addr (base_addr),
    .in0       (vin[0]),
    .in1       (vin[1]),
    .in2       (vin[2]),
    .in3       (vin[3]),
    .in4       (vin[4]),
    .in5       (vin[5]),
    .in6       (vin[6]),
    .in7       (vin[7]),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Entered and left at a negedge with the DUT idle; the next call may
  // follow immediately, which exercises back-to-back starts.
  task automatic run_seq(input logic [7:0] m, input logic [15:0] b,
                         input int stall_n, input bit rnd_rdy,
                         input bit poke);
    int          qs [$];
    logic [15:0] qd [$];
    logic [15:0] qa [$];
    logic [15:0] a;
    int          cyc;
    int          n_valid;
    int          n_stall;
    bit          fin_seen;
    a = b;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) begin
        qs.push_back(k);
        qd.push_back(vin[k]);
        qa.push_back(a);
        a = a + 16'd1;
      end
    end
    chk("idle_busy", {31'd0, busy}, 32'd0);
    mask      = m;
    base_addr = b;
    start     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start     = 1'b0;
    mask      = 8'($urandom);
    base_addr = 16'($urandom);
    cyc       = 0;
    n_valid   = 0;
    n_stall   = 0;
    fin_seen  = 1'b0;
    while (!fin_seen && cyc < 200) begin
      start = 1'b0;
      if (qs.size() == 0) begin
        chk("fin_done", {31'd0, done}, 32'd1);
        chk("fin_busy", {31'd0, busy}, 32'd1);
        chk("fin_valid", {31'd0, out_valid}, 32'd0);
        fin_seen = 1'b1;
      end else begin
        chk("valid", {31'd0, out_valid}, 32'd1);
        chk("sel", {29'd0, out_sel}, 32'(qs[0]));
        chk("data", {16'd0, out_data}, {16'd0, qd[0]});
        chk("addr", {16'd0, out_addr}, {16'd0, qa[0]});
        chk("send_done", {31'd0, done}, 32'd0);
        chk("send_busy", {31'd0, busy}, 32'd1);
        n_valid++;
        if (cyc < stall_n) out_ready = 1'b0;
        else if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        else out_ready = 1'b1;
        if (!out_ready) n_stall++;
        if (poke && cyc == 1) begin
          for (int k = 0; k < 4; k++) vin[k] = 16'($urandom);
          start = 1'b1;
        end
        if (out_ready) begin
          void'(qs.pop_front());
          void'(qd.pop_front());
          void'(qa.pop_front());
        end
      end
      cyc++;
      @(negedge clk);
    end
    if (!fin_seen) chk("timeout", 32'd0, 32'd1);
    chk("valid_cycles", 32'(n_valid), 32'($countones(m)) + 32'(n_stall));
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("post_done", {31'd0, done}, 32'd0);
    start     = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mask      = '0;
    base_addr = '0;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) vin[k] = 16'h1000 + 16'(k);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_addr", {16'd0, out_addr}, 32'd0);
    chk("rst_sel", {29'd0, out_sel}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_seq(8'b1010_0101, 16'h0100, 0, 1'b0, 1'b0);
    run_seq(8'h01, 16'h0200, 3, 1'b0, 1'b0);
    run_seq(8'h00, 16'h0300, 0, 1'b0, 1'b0);
    run_seq(8'hFF, 16'hFFFE, 0, 1'b0, 1'b0);
    run_seq(8'h0F, 16'h0400, 0, 1'b1, 1'b1);

    for (int k = 0; k < 8; k++) vin[k] = 16'($urandom);
    mask      = 8'hFF;
    base_addr = 16'h0500;
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_done", {31'd0, done}, 32'd0);
    chk("ar_data", {16'd0, out_data}, 32'd0);
    chk("ar_addr", {16'd0, out_addr}, 32'd0);
    chk("ar_sel", {29'd0, out_sel}, 32'd0);
    @(negedge clk);
    chk("ar_hold_done", {31'd0, done}, 32'd0);
    rst       = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("ar_post_done", {31'd0, done}, 32'd0);
    chk("ar_post_busy", {31'd0, busy}, 32'd0);
    run_seq(8'h3C, 16'h0600, 0, 1'b0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < 8; k++) vin[k] = 16'($urandom);
      run_seq(8'($urandom), 16'($urandom), $urandom_range(0, 2),
              1'b1, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/store_multiple_seq.md
STORE_MULTIPLE_SEQ -- requirements
Module: store_multiple_seq

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  request to begin a store-multiple sequence.
REQ-005 mask  in  8  register-select bits; bit i selects register i.
REQ-006 base_addr  in  16  memory address for the first transferred word.
REQ-007 in0..in7  in  16 each  register values R0..R7.
REQ-008 out_data  out  16  selected register value for the current transfer.
REQ-009 out_addr  out  16  memory address for the current transfer.
REQ-010 out_sel  out  3  index of the register currently presented.
REQ-011 out_valid  out  1  out_data/out_addr/out_sel are valid.
REQ-012 out_ready  in  1  downstream accepts the current word.
REQ-013 busy  out  1  sequence in progress.
REQ-014 done  out  1  one-cycle pulse at the end of a sequence.

Function
REQ-015 SHALL implement FSM states IDLE, SEND and FIN.
REQ-016 In IDLE with start=1, SHALL capture mask, base_addr and in0..in7 into internal snapshot registers.
- Later changes on those inputs SHALL NOT affect the sequence.
REQ-017 IDLE + start + mask!=0 SHALL move to SEND on the next edge.
- out_valid=1 in the first SEND cycle (start-to-valid latency 1 cycle).
REQ-018 IDLE + start + mask==0 SHALL move directly to FIN.
- out_valid SHALL never assert for such a sequence.
REQ-019 In SEND, SHALL present the lowest-index set bit of the remaining mask.
- out_sel = that index.
- out_data = snapshot of that register.
- out_addr = base_addr + number of words already transferred.
REQ-020 A transfer SHALL occur only on a cycle with out_valid=1 and out_ready=1.
- The presented bit is cleared from the remaining mask.
- out_addr increments by 1, modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-021 While out_valid=1 and out_ready=0, out_data, out_addr and out_sel SHALL hold stable and out_valid SHALL stay 1.
REQ-022 SHALL move SEND to FIN on the transfer of the last remaining selected word.
- out_valid=0 in FIN.
REQ-023 FIN SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 busy SHALL be 1 in SEND and FIN and 0 in IDLE.
REQ-025 start SHALL be ignored in SEND and FIN; no restart and no snapshot update.
REQ-026 Number of transfers SHALL equal popcount(mask); order SHALL be strictly ascending register index.
REQ-027 Back-to-back operation: start asserted in the cycle after FIN SHALL be accepted, because the block is then in IDLE.

Reset
REQ-028 rst=1 SHALL immediately force the following, independent of clk:
- state IDLE
- out_data, out_addr, out_sel = 0
- out_valid, busy, done = 0
- remaining mask and snapshot registers = 0
REQ-029 Reset during SEND or FIN SHALL abort the sequence with no done pulse.
- After rst deasserts, the block SHALL accept a new start normally.

Verification
REQ-030 Bench SHALL apply: mask=8'b1010_0101, base_addr=0x0100, inK=0x1000+K, out_ready=1.
- Required: 4 transfers, one per cycle.
- (sel,data,addr) = (0,0x1000,0x0100), (2,0x1002,0x0101), (5,0x1005,0x0102), (7,0x1007,0x0103).
- done pulses the cycle after the last transfer.
REQ-031 Bench SHALL apply: mask=8'h01, out_ready=0 for 3 cycles then 1.
- Required: out_valid held 4 cycles with sel=0 and data/addr stable.
- Single transfer, then done.
REQ-032 Bench SHALL apply: mask=8'h00 with start.
- Required: out_valid never asserts.
- busy=1 for one cycle and done=1 in that same cycle.
REQ-033 Bench SHALL apply: mask=8'hFF, base_addr=0xFFFE.
- Required: addresses 0xFFFE, 0xFFFF, 0x0000 ... 0x0005 across 8 transfers.
REQ-034 Bench SHALL apply: start with mask=8'h0F; change in0..in3 and re-pulse start mid-sequence.
- Required: original snapshot values transferred, second start ignored.
REQ-035 Bench SHALL apply: rst asserted asynchronously mid-SEND, between clock edges.
- Required: all outputs 0 immediately, no done pulse.
- A fresh start after reset completes correctly.
